// File: rtl/rat_intr_ctrl.sv
// rat_intr_ctrl: RAT MCU interrupt controller (sync, edge detect, mask, I flag, port-bus registers)
// Define RAT_INTR_LEVEL_EN to add the TYPE register and per-source level-triggered mode.
module rat_intr_ctrl #(
  parameter int         NUM_SRC     = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] MASK_PORT   = 8'h20,
  parameter logic [7:0] PEND_PORT   = 8'h21,
  parameter logic [7:0] CAUSE_PORT  = 8'h22,
  parameter logic [7:0] TYPE_PORT   = 8'h23
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] INT_SRC,
  input  logic               I_SET,
  input  logic               I_CLR,
  input  logic               INT_ACK,
  input  logic               IO_STRB,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  output logic [7:0]         IN_DATA,
  output logic               IN_HIT,
  output logic               INTR,
  output logic               I_FLAG
);
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s, prev, pend, evt, qual, ack_clr, w1c, lvl, pend_nxt;
  logic [7:0] mask, cause, trig_type;
  logic [2:0] w;
  logic i_q, ack_ok, hit_mask, hit_pend, hit_cause, hit_type;
  assign s        = sync_q[SYNC_STAGES-1];
  assign evt      = s & ~prev;
  assign qual     = pend & mask[NUM_SRC-1:0];
  assign ack_ok   = INT_ACK & |qual;
  assign ack_clr  = ack_ok ? NUM_SRC'(1) << w : '0;
  assign hit_mask  = PORT_ID == MASK_PORT;
  assign hit_pend  = PORT_ID == PEND_PORT;
  assign hit_cause = PORT_ID == CAUSE_PORT;
  assign w1c      = (IO_STRB & hit_pend) ? OUT_PORT[NUM_SRC-1:0] : '0;
  // a fresh event always wins over a coincident ACK or W1C clear
  assign pend_nxt = (lvl & s) | (~lvl & (evt | (pend & ~ack_clr & ~w1c)));
  assign INTR     = i_q & |qual;
  assign I_FLAG   = i_q;
  assign IN_HIT   = hit_mask | hit_pend | hit_cause | hit_type;
  assign IN_DATA  = hit_mask ? mask : hit_pend ? 8'(pend) : hit_cause ? cause : hit_type ? trig_type : 8'h00;
  always_comb begin
    w = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (qual[i]) w = 3'(i);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev  <= '0;
      pend  <= '0;
      mask  <= '0;
      cause <= '0;
      i_q   <= 1'b0;
    end else begin
      sync_q[0] <= INT_SRC;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= s;
      pend <= pend_nxt;
      i_q  <= I_CLR ? 1'b0 : I_SET ? 1'b1 : i_q;
      if (IO_STRB & hit_mask) mask <= OUT_PORT;
      if (ack_ok) cause <= {5'b0, w} | 8'h80;
    end
  end
`ifdef RAT_INTR_LEVEL_EN
  assign hit_type = PORT_ID == TYPE_PORT;
  assign lvl      = trig_type[NUM_SRC-1:0];
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) trig_type <= '0;
    else if (IO_STRB & hit_type) trig_type <= OUT_PORT;
  end
`else
  assign hit_type  = 1'b0;
  assign trig_type = 8'h00;
  assign lvl       = '0;
`endif
endmodule
